// File: rtl/alu_shift_add_multiplier_pkg.sv
// rtl/alu_shift_add_multiplier_pkg.sv - shared ALU codes and multiplier state encoding
//
// Purpose: constants shared by the ALU, the main control unit and the
//          shift-and-add multiplier.
// Contents: DATA_WIDTH, ALU control codes, multiplier FSM state type.
package alu_shift_add_multiplier_pkg;

  localparam int DATA_WIDTH = 32;

  // ALU control codes understood by the shared combinational ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/alu_shift_add_multiplier_if.sv
// rtl/alu_shift_add_multiplier_if.sv - request/result handshake and ALU bus of the multiplier
//
// Purpose: bundles the start/done handshake and the ALU operand/control bus.
// Signals:
//   start, multiplicand, multiplier      requester -> multiplier
//   busy, result_valid, result           multiplier -> requester
//   alu_input_1, alu_input_2, alu_control multiplier -> ALU
//   alu_result                            ALU -> multiplier
// Modports: slave (the multiplier), master (requester side incl. the ALU hookup).
interface alu_shift_add_multiplier_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_input_1;
  logic [WIDTH-1:0] alu_input_2;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, multiplicand, multiplier, alu_result,
    output busy, result_valid, result, alu_input_1, alu_input_2, alu_control
  );

  modport master (
    output start, multiplicand, multiplier, alu_result,
    input  busy, result_valid, result, alu_input_1, alu_input_2, alu_control
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - shared single-cycle combinational ALU
//
// Purpose: add/sub/and/or on two WIDTH-bit operands, no carry output.
// Ports:
//   input_1, input_2  operands
//   alu_control       operation code (see package)
//   alu_result        combinational result, modulo 2^WIDTH
module alu
  import alu_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_result
);

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = input_1 + input_2;
      ALU_SUB: alu_result = input_1 - input_2;
      ALU_AND: alu_result = input_1 & input_2;
      ALU_OR:  alu_result = input_1 | input_2;
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_shift_add_multiplier.sv
// rtl/alu_shift_add_multiplier.sv - multi-cycle shift-and-add multiplier using the shared ALU
//
// Purpose: low WIDTH bits of an unsigned product (MUL semantics), one ALU ADD per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    slave side of alu_shift_add_multiplier_if:
//            start/multiplicand/multiplier in, busy/result_valid/result out,
//            alu_input_1/alu_input_2/alu_control out, alu_result in
module alu_shift_add_multiplier #(
  parameter int         WIDTH   = 32,
  parameter logic [1:0] ALU_ADD = alu_shift_add_multiplier_pkg::ALU_ADD
) (
  input  logic                        clk,
  input  logic                        reset,
  alu_shift_add_multiplier_if.slave   bus
);

  import alu_shift_add_multiplier_pkg::*;

  localparam int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             valid_q;

  logic [WIDTH-1:0] acc_next;
  logic             last_step;

  // Accumulate only when the current multiplier bit is set; the ALU sum
  // is acc + mcand because the ALU operands below are acc and mcand.
  assign acc_next  = mplier[0] ? bus.alu_result : acc;
  // Early-out once no set bits remain above the one being consumed now.
  assign last_step = ((mplier >> 1) == '0) || (count == LAST_COUNT);

  // The shared ALU sees zero operands outside RUN.
  assign bus.alu_input_1 = (state == ST_RUN) ? acc   : '0;
  assign bus.alu_input_2 = (state == ST_RUN) ? mcand : '0;
  assign bus.alu_control = ALU_ADD;

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            mcand  <= bus.multiplicand;
            mplier <= bus.multiplier;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_step) begin
            result_q <= acc_next;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_add_multiplier.sv
// tb/tb_alu_shift_add_multiplier.sv - self-checking bench for alu_shift_add_multiplier
module tb_alu_shift_add_multiplier;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  int   rv_count;
  int   overlap_seen;

  alu_shift_add_multiplier_if #(.WIDTH(W)) bus ();

  alu_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  alu #(.WIDTH(W)) u_alu (
    .input_1     (bus.alu_input_1),
    .input_2     (bus.alu_input_2),
    .alu_control (bus.alu_control),
    .alu_result  (bus.alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.result_valid) rv_count++;
    if (bus.result_valid && bus.busy) overlap_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_length(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Expected low word of a times the low k bits of b.
  function automatic logic [W-1:0] partial_product(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [63:0] mask;
    logic [63:0] p;
    mask = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
    p = 64'(a) * (64'(b) & mask);
    return p[W-1:0];
  endfunction

  // Starts a multiply and follows it to completion. If reload_at >= 0 a
  // second start with different operands is pulsed during that RUN cycle.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int reload_at);
    int          cycles;
    int          exp_n;
    int          path_err;
    int          rv0;
    logic [63:0] full;
    logic [W-1:0] exp_res;
    full    = 64'(a) * 64'(b);
    exp_res = full[W-1:0];
    exp_n   = (bit_length(b) == 0) ? 1 : bit_length(b);
    path_err = 0;
    rv0 = rv_count;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      if (bus.alu_control !== 2'b00) path_err++;
      if (bus.alu_input_2 !== W'(64'(a) << cycles)) path_err++;
      if (bus.alu_input_1 !== partial_product(a, b, cycles)) path_err++;
      if (bus.result_valid) path_err++;
      if (cycles == reload_at) begin
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'd5;
        bus.start        = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cycles++;
    end
    check({tag, "_cycles"}, 64'(cycles), 64'(exp_n));
    check({tag, "_alu_path"}, 64'(path_err), 64'd0);
    check({tag, "_valid"}, {63'd0, bus.result_valid}, 64'd1);
    check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, {63'd0, bus.result_valid}, 64'd0);
    check({tag, "_held"}, 64'(bus.result), 64'(exp_res));
    check({tag, "_pulses"}, 64'(rv_count - rv0), 64'd1);
    check({tag, "_idle_alu"}, {bus.alu_input_1, bus.alu_input_2}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int rv0;
    n_compared   = 0;
    n_mismatched = 0;
    rv_count     = 0;
    overlap_seen = 0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {63'd0, bus.busy}, 64'd0);
    check("rst_valid",  {63'd0, bus.result_valid}, 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_alu",    {bus.alu_input_1, bus.alu_input_2}, 64'd0);
    check("rst_ctl",    64'(bus.alu_control), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_mul("m23x42", 32'd23, 32'd42, -1);
    run_mul("max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_mul("by0",    32'h1234_5678, 32'd0, -1);
    run_mul("by1",    32'h1234_5678, 32'd1, -1);
    run_mul("m7x9",   32'd7, 32'd9, 1);
    run_mul("m5x5",   32'd5, 32'd5, -1);

    // Abandon a long multiply with an asynchronous reset mid-RUN.
    bus.multiplicand = 32'h0001_0000;
    bus.multiplier   = 32'h8000_0000;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    rv0 = rv_count;
    reset = 1'b1;
    #1;
    check("async_busy",   {63'd0, bus.busy}, 64'd0);
    check("async_result", 64'(bus.result), 64'd0);
    check("async_alu",    {bus.alu_input_1, bus.alu_input_2}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abandon_pulses", 64'(rv_count - rv0), 64'd0);
    check("abandon_idle",   {63'd0, bus.busy}, 64'd0);

    run_mul("wrap",   32'h0001_0000, 32'h0000_8000, -1);
    run_mul("hi_cut", 32'h0001_0000, 32'h0001_0000, -1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_mul($sformatf("rnd%0d", i), ra, rb, ($urandom_range(0, 3) == 0) ? 0 : -1);
    end

    check("busy_valid_overlap", 64'(overlap_seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_shift_add_multiplier.md
Name: alu_shift_add_multiplier

Overview:
- Sequential initiator on the ALU operand/control interface.
- Computes the low WIDTH bits of an unsigned product (RISC-V MUL semantics) by shift-and-add.
- Issues one ADD to the shared combinational ALU per cycle and captures alu_result.
- Sits beside the single-cycle datapath as a multi-cycle M-extension helper with a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width; must equal the ALU data width.
- ALU_ADD, 2'b00, ALU control code for add (ALU codes: 00 add, 01 sub, 10 and, 11 or).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- multiplicand  input  WIDTH  operand A, captured on accepted start
- multiplier  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while in RUN
- result_valid  output  1  one-cycle pulse, high only in DONE
- result  output  WIDTH  low WIDTH bits of A*B; held stable until the next accepted start
- alu_input_1  output  WIDTH  to ALU input_1: accumulator
- alu_input_2  output  WIDTH  to ALU input_2: shifted multiplicand
- alu_control  output  2  to ALU alu_control
- alu_result  input  WIDTH  from ALU; combinational in the same cycle

Behaviour:
- Reset (async, immediate, from any state):
  - state=IDLE; acc, mcand, mplier, count, result=0; busy=0; result_valid=0.
  - ALU outputs driven 0 with alu_control=ALU_ADD.
  - Reset mid-RUN abandons the operation; no result_valid is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a clock edge: acc<=0, mcand<=multiplicand, mplier<=multiplier, count<=0; go to RUN.
  - With start=0: stay in IDLE.
- RUN:
  - Drive alu_input_1=acc, alu_input_2=mcand, alu_control=ALU_ADD.
  - Each edge:
    - If mplier[0], acc<=alu_result; otherwise acc is unchanged.
    - mcand<=mcand<<1 (zero fill, MSB discarded).
    - mplier<=mplier>>1.
    - count<=count+1.
  - Exit to DONE on the edge where (mplier>>1)==0 or count==WIDTH-1, with result<=next acc.
  - Early-out: number of RUN cycles N = max(1, bit-length of multiplier), maximum WIDTH.
- DONE: result_valid=1 for exactly one cycle; then IDLE on the next edge.
- Latency: result_valid is high in the cycle following the N-th edge after the start-sampling edge.
- Arithmetic: all addition is modulo 2^WIDTH. The ALU has no carry output and none is needed for the low word.
- start in RUN or DONE is ignored, not queued; operand changes after acceptance have no effect.
- Outside RUN, alu_input_1/alu_input_2 are driven 0 (no spurious activity on a shared ALU).
- busy and result_valid are never high simultaneously.

Decomposition:
- Shared package holds:
  - ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR), shared with the ALU and the main control unit.
  - State encoding constants for IDLE/RUN/DONE.
- No sub-module: the control FSM and the shift registers are one block.
- The ALU stays external; the bench instantiates the existing alu and wires it to the alu_* ports.

Test Plan:
- Reset, then multiplicand=23, multiplier=42, start pulse -> busy for 6 cycles, alu_control=00 throughout, result_valid one cycle with result=966.
- 0xFFFFFFFF x 0xFFFFFFFF -> 32 RUN cycles (maximum latency), result=0x00000001.
- multiplier=0, multiplicand=0x12345678 -> N=1, result=0 after 1 RUN cycle; multiplier=1 -> result=0x12345678 after 1 RUN cycle.
- 7x9 started, then start re-pulsed with 5x5 during RUN -> second request ignored, result=63; a later start in IDLE with 5x5 gives 25.
- Assert reset at RUN cycle 3 of 0x10000 x 0x80000000 -> outputs zero at once, no result_valid pulse; next start with 0x10000 x 0x8000 -> result=0x80000000, overflow wraps correctly.
- 0x00010000 x 0x00010000 -> result=0 (high bits discarded), result_valid asserted exactly once.
